load_unit: RTL and testbench

- Parametrised, handshaked successor to the combinational load-extension logic in the MEM stage.
- Accepts one load request per transaction: op plus low address bits. Checks alignment, issues the bus read, and waits a variable number of cycles for the data response.
- Selects the addressed byte/half/word/dword and sign- or zero-extends it.
- Holds the result until the pipeline consumes it. Supports flush of an in-flight load.

---
 rtl/load_pkg.sv | 42 ++++
 rtl/load_extend.sv | 37 +++
 rtl/load_unit.sv | 110 +++++++++++
 tb/tb_load_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared load-op encodings, FSM state codes and alignment helpers for the load unit.
package load_pkg;

  typedef logic [2:0] load_op_t;

  localparam load_op_t OpLw  = 3'b000;
  localparam load_op_t OpLh  = 3'b001;
  localparam load_op_t OpLb  = 3'b010;
  localparam load_op_t OpLhu = 3'b011;
  localparam load_op_t OpLbu = 3'b100;
  localparam load_op_t OpLwu = 3'b101;
  localparam load_op_t OpLd  = 3'b110;

  typedef logic [1:0] load_state_t;

  localparam load_state_t StIdle  = 2'd0;
  localparam load_state_t StWait  = 2'd1;
  localparam load_state_t StDone  = 2'd2;
  localparam load_state_t StDrain = 2'd3;

  // LD/LWU only exist on a 64-bit datapath; 3'b111 is never defined.
  function automatic logic load_reserved(input load_op_t op, input int unsigned data_w);
    case (op)
      OpLd, OpLwu: return data_w != 64;
      3'b111:      return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  // Reserved ops are treated as aligned so they complete with zero data.
  function automatic logic load_misaligned(input load_op_t op, input logic [2:0] off,
                                           input int unsigned data_w);
    if (load_reserved(op, data_w)) return 1'b0;
    case (op)
      OpLw, OpLwu: return off[1:0] != 2'b00;
      OpLh, OpLhu: return off[0];
      OpLd:        return off != 3'b000;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of bus read data for one load op.
module load_extend
  import load_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  load_op_t          op,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] data
);

  logic [63:0] wide;
  logic [31:0] lane;

  // Work on a 64-bit copy so one body serves both widths; truncation drops the excess.
  always_comb begin
    wide               = '0;
    wide[DATA_W-1:0]   = rdata;
    lane               = 32'(wide >> {off, 3'b000});
    data               = '0;
    if (!load_reserved(op, DATA_W)) begin
      case (op)
        OpLb:    data = DATA_W'({{56{lane[7]}}, lane[7:0]});
        OpLbu:   data = DATA_W'({56'd0, lane[7:0]});
        OpLh:    data = DATA_W'({{48{lane[15]}}, lane[15:0]});
        OpLhu:   data = DATA_W'({48'd0, lane[15:0]});
        OpLw:    data = DATA_W'({{32{lane[31]}}, lane});
        OpLwu:   data = DATA_W'({32'd0, lane});
        OpLd:    data = DATA_W'(wide);
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_unit.sv
// Handshaked load unit: alignment check, bus read, variable-latency wait, extension and hold.
module load_unit
  import load_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [OFF_W-1:0]  req_off,
  input  logic              flush,
  output logic              mem_rd_en,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_exc_adel
);

  load_state_t       state_q, state_d;
  load_op_t          op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              exc_q, exc_d;
  logic [DATA_W-1:0] ext_data;
  logic              accept;
  logic              misaligned;

  load_extend #(
    .DATA_W (DATA_W)
  ) u_extend (
    .rdata (mem_rdata),
    .op    (op_q),
    .off   (off_q),
    .data  (ext_data)
  );

  // Gating with reset keeps the bus strobe quiet while reset is held.
  assign req_ready  = reset && !flush &&
                      ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept     = req_valid && req_ready;
  assign misaligned = load_misaligned(req_op, 3'(req_off), DATA_W);
  assign mem_rd_en  = accept && !misaligned;

  assign out_valid    = (state_q == StDone);
  assign out_data     = data_q;
  assign out_exc_adel = exc_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    data_d  = data_q;
    exc_d   = exc_q;

    case (state_q)
      StIdle: ;
      StWait: begin
        if (flush) begin
          state_d = mem_rsp_valid ? StIdle : StDrain;
        end else if (mem_rsp_valid) begin
          data_d  = ext_data;
          exc_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (flush || out_ready) state_d = StIdle;
      end
      StDrain: begin
        if (mem_rsp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Accepts only happen in IDLE or in DONE while the result is consumed.
    if (accept) begin
      op_d  = req_op;
      off_d = req_off;
      if (misaligned) begin
        data_d  = '0;
        exc_d   = 1'b1;
        state_d = StDone;
      end else begin
        state_d = StWait;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      off_q   <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed-vector bench for load_unit at DATA_W=32 and DATA_W=64.
module tb_load_unit;

  logic clk = 1'b0;
  logic reset;

  logic        a_req_valid, a_req_ready, a_flush, a_rd_en, a_rsp_valid;
  logic        a_out_valid, a_out_ready, a_exc;
  logic [2:0]  a_op;
  logic [1:0]  a_off;
  logic [31:0] a_rdata, a_out_data;

  logic        b_req_valid, b_req_ready, b_flush, b_rd_en, b_rsp_valid;
  logic        b_out_valid, b_out_ready, b_exc;
  logic [2:0]  b_op;
  logic [2:0]  b_off;
  logic [63:0] b_rdata, b_out_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_unit #(.DATA_W(32)) u_dut32 (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (a_req_valid),
    .req_ready     (a_req_ready),
    .req_op        (a_op),
    .req_off       (a_off),
    .flush         (a_flush),
    .mem_rd_en     (a_rd_en),
    .mem_rsp_valid (a_rsp_valid),
    .mem_rdata     (a_rdata),
    .out_valid     (a_out_valid),
    .out_ready     (a_out_ready),
    .out_data      (a_out_data),
    .out_exc_adel  (a_exc)
  );

  load_unit #(.DATA_W(64)) u_dut64 (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (b_req_valid),
    .req_ready     (b_req_ready),
    .req_op        (b_op),
    .req_off       (b_off),
    .flush         (b_flush),
    .mem_rd_en     (b_rd_en),
    .mem_rsp_valid (b_rsp_valid),
    .mem_rdata     (b_rdata),
    .out_valid     (b_out_valid),
    .out_ready     (b_out_ready),
    .out_data      (b_out_data),
    .out_exc_adel  (b_exc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later still.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a_req_valid = 1'b1; a_op = 3'b010; a_off = 2'd0; a_flush = 1'b0;
    a_rsp_valid = 1'b0; a_rdata = '0; a_out_ready = 1'b0;
    b_req_valid = 1'b0; b_op = 3'b000; b_off = 3'd0; b_flush = 1'b0;
    b_rsp_valid = 1'b0; b_rdata = '0; b_out_ready = 1'b0;
    reset = 1'b0;

    // Reset, with a request pending that must not strobe the bus
    step(); step(); settle();
    check("rst_rd_en", 64'(a_rd_en), 64'd0);
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_data", 64'(a_out_data), 64'd0);
    check("rst_exc", 64'(a_exc), 64'd0);
    reset = 1'b1; a_req_valid = 1'b0; settle();
    check("rst_ready", 64'(a_req_ready), 64'd1);

    // LB off 3, response one cycle after the strobe
    a_req_valid = 1'b1; a_op = 3'b010; a_off = 2'd3; settle();
    check("lb_rd_en", 64'(a_rd_en), 64'd1);
    step(); a_req_valid = 1'b0; a_rsp_valid = 1'b1; a_rdata = 32'h80FF_1234; settle();
    check("lb_wait_valid", 64'(a_out_valid), 64'd0);
    check("lb_wait_rd_en", 64'(a_rd_en), 64'd0);
    step(); a_rsp_valid = 1'b0; settle();
    check("lb_valid", 64'(a_out_valid), 64'd1);
    check("lb_data", 64'(a_out_data), 64'hFFFF_FF80);
    check("lb_exc", 64'(a_exc), 64'd0);
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0; settle();
    check("lb_drop", 64'(a_out_valid), 64'd0);

    // LHU off 2, slow response, result held under back-pressure
    a_req_valid = 1'b1; a_op = 3'b011; a_off = 2'd2; settle();
    check("lhu_rd_en", 64'(a_rd_en), 64'd1);
    step(); a_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle(); check("lhu_wait", 64'(a_out_valid), 64'd0); step();
    end
    a_rsp_valid = 1'b1; a_rdata = 32'h8001_0000;
    step(); a_rsp_valid = 1'b0; a_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lhu_hold_valid", 64'(a_out_valid), 64'd1);
      check("lhu_hold_data", 64'(a_out_data), 64'h0000_8001);
      step();
    end
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0; settle();
    check("lhu_drop", 64'(a_out_valid), 64'd0);

    // Misaligned LW
    a_req_valid = 1'b1; a_op = 3'b000; a_off = 2'd1; settle();
    check("adel_rd_en", 64'(a_rd_en), 64'd0);
    step(); a_req_valid = 1'b0; settle();
    check("adel_valid", 64'(a_out_valid), 64'd1);
    check("adel_exc", 64'(a_exc), 64'd1);
    check("adel_data", 64'(a_out_data), 64'd0);
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0; settle();
    check("adel_drop", 64'(a_out_valid), 64'd0);

    // Flush in WAIT, response two cycles later is drained
    a_req_valid = 1'b1; a_op = 3'b010; a_off = 2'd0;
    step(); a_req_valid = 1'b0; a_flush = 1'b1; settle();
    check("fl_ready_flush", 64'(a_req_ready), 64'd0);
    step(); a_flush = 1'b0; settle();
    check("fl_drain_ready", 64'(a_req_ready), 64'd0);
    check("fl_drain_valid", 64'(a_out_valid), 64'd0);
    step(); a_rsp_valid = 1'b1; a_rdata = 32'h0000_0055; settle();
    check("fl_drain_ready2", 64'(a_req_ready), 64'd0);
    step(); a_rsp_valid = 1'b0; settle();
    check("fl_idle_ready", 64'(a_req_ready), 64'd1);
    check("fl_idle_valid", 64'(a_out_valid), 64'd0);

    // Flush in WAIT together with the response goes straight to IDLE
    a_req_valid = 1'b1; a_op = 3'b010; a_off = 2'd0;
    step(); a_req_valid = 1'b0; a_flush = 1'b1; a_rsp_valid = 1'b1;
    step(); a_flush = 1'b0; a_rsp_valid = 1'b0; settle();
    check("flrsp_ready", 64'(a_req_ready), 64'd1);
    check("flrsp_valid", 64'(a_out_valid), 64'd0);

    // Back-to-back LB requests
    a_req_valid = 1'b1; a_op = 3'b010; a_off = 2'd0;
    step(); a_req_valid = 1'b0; a_rsp_valid = 1'b1; a_rdata = 32'h0000_007F;
    step(); a_rsp_valid = 1'b0; settle();
    check("b2b_first", 64'(a_out_data), 64'h0000_007F);
    a_out_ready = 1'b1; a_req_valid = 1'b1; a_off = 2'd1; settle();
    check("b2b_ready", 64'(a_req_ready), 64'd1);
    check("b2b_rd_en", 64'(a_rd_en), 64'd1);
    step(); a_req_valid = 1'b0; a_out_ready = 1'b0;
    a_rsp_valid = 1'b1; a_rdata = 32'h0000_8000; settle();
    check("b2b_wait_valid", 64'(a_out_valid), 64'd0);
    step(); a_rsp_valid = 1'b0; settle();
    check("b2b_valid", 64'(a_out_valid), 64'd1);
    check("b2b_second", 64'(a_out_data), 64'hFFFF_FF80);
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0;

    // LD is reserved at 32 bits: aligned, zero data, no exception
    a_req_valid = 1'b1; a_op = 3'b110; a_off = 2'd0; settle();
    check("rsv_rd_en", 64'(a_rd_en), 64'd1);
    step(); a_req_valid = 1'b0; a_rsp_valid = 1'b1; a_rdata = 32'hFFFF_FFFF;
    step(); a_rsp_valid = 1'b0; settle();
    check("rsv_data", 64'(a_out_data), 64'd0);
    check("rsv_exc", 64'(a_exc), 64'd0);
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0;

    // LBU then flush in DONE drops the result
    a_req_valid = 1'b1; a_op = 3'b100; a_off = 2'd0;
    step(); a_req_valid = 1'b0; a_rsp_valid = 1'b1; a_rdata = 32'hFFFF_FFAB;
    step(); a_rsp_valid = 1'b0; settle();
    check("lbu_data", 64'(a_out_data), 64'h0000_00AB);
    a_flush = 1'b1; step(); a_flush = 1'b0; settle();
    check("fldone_valid", 64'(a_out_valid), 64'd0);
    check("fldone_ready", 64'(a_req_ready), 64'd1);

    // Reset in WAIT, then a stray response
    a_req_valid = 1'b1; a_op = 3'b001; a_off = 2'd0;
    step(); a_req_valid = 1'b0; reset = 1'b0;
    step(); reset = 1'b1; settle();
    check("rstw_valid", 64'(a_out_valid), 64'd0);
    check("rstw_data", 64'(a_out_data), 64'd0);
    check("rstw_exc", 64'(a_exc), 64'd0);
    check("rstw_ready", 64'(a_req_ready), 64'd1);
    a_rsp_valid = 1'b1; a_rdata = 32'h0000_1234;
    step(); a_rsp_valid = 1'b0; settle();
    check("stray_valid", 64'(a_out_valid), 64'd0);
    check("stray_data", 64'(a_out_data), 64'd0);
    check("stray_ready", 64'(a_req_ready), 64'd1);

    // 64-bit datapath: LWU and LW of the upper word, misaligned LD
    b_req_valid = 1'b1; b_op = 3'b101; b_off = 3'd4; settle();
    check("w64_lwu_rd_en", 64'(b_rd_en), 64'd1);
    step(); b_req_valid = 1'b0; b_rsp_valid = 1'b1; b_rdata = 64'h8765_4321_0000_0000;
    step(); b_rsp_valid = 1'b0; settle();
    check("w64_lwu_data", b_out_data, 64'h0000_0000_8765_4321);
    b_out_ready = 1'b1; b_req_valid = 1'b1; b_op = 3'b000; b_off = 3'd4;
    step(); b_req_valid = 1'b0; b_out_ready = 1'b0; b_rsp_valid = 1'b1;
    step(); b_rsp_valid = 1'b0; settle();
    check("w64_lw_data", b_out_data, 64'hFFFF_FFFF_8765_4321);
    b_out_ready = 1'b1; b_req_valid = 1'b1; b_op = 3'b110; b_off = 3'd4; settle();
    check("w64_ld_rd_en", 64'(b_rd_en), 64'd0);
    step(); b_req_valid = 1'b0; b_out_ready = 1'b0; settle();
    check("w64_ld_exc", 64'(b_exc), 64'd1);
    check("w64_ld_data", b_out_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
